varredura_display: RTL and testbench
====================================

VARREDURA_DISPLAY -- requirements
Module: varredura_display

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, giving clock cycles per digit slot (legal range 4..2^20).
REQ-002 The block SHALL have parameter BLANK_CYC, default 500, giving anti-ghost blanking cycles at the start of each slot (legal range 1..DIV-2).
REQ-003 Port clk, input, 1, the single rising-edge clock.
REQ-004 Port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 Port en, input, 1, scan enable.
REQ-006 Port lz_en, input, 1, leading-zero suppression enable.
REQ-007 Port load_valid, input, 1, new-value request.
REQ-008 Port load_data, input, 16, four BCD digits, [15:12]=digit3 (most significant) .. [3:0]=digit0.
REQ-009 Port load_ready, output, 1, pending slot free.
REQ-010 Port an, output, 4, active-low digit enables, an[i] drives digit i.
REQ-011 Port seg, output, 7, active-low segments, seg[0:6]=a..g.
REQ-012 Port frame_start, output, 1, one-cycle pulse when digit 0's slot begins.

Function
REQ-013 Slot counter SHALL count 0..DIV-1 while en=1 and wrap to 0, advancing digit index 0->1->2->3->0 on wrap.
REQ-014 FSM SHALL have states BLANK and SHOW: BLANK at slot count 0, SHOW at count BLANK_CYC, back to BLANK on wrap.
REQ-015 In BLANK, an SHALL be 4'b1111 and seg 7'b1111111.
REQ-016 In SHOW, an SHALL have only bit [index] low and seg SHALL be the decoded nibble of the display register for that index.
REQ-017 Decode SHALL be active-low a..g: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, 10..15=0110000 ("E").
REQ-018 With lz_en=1, digit i (i=3..1) SHALL display 7'b1111111 while its an bit is still asserted if it and every higher digit are 0; digit 0 SHALL never be suppressed.
REQ-019 an and seg SHALL be registered: they reflect FSM state/index one cycle after the state change.
REQ-020 When load_valid=1 and load_ready=1, load_data SHALL be captured into the pending register and load_ready SHALL drop the next cycle.
REQ-021 Pending contents SHALL transfer to the display register in the cycle the index wraps 3->0, and load_ready SHALL rise the following cycle.
REQ-022 An acceptance in the same cycle as a 3->0 wrap SHALL not transfer until the next wrap; transfer uses only a pending value that existed before that cycle.
REQ-023 frame_start SHALL pulse for one cycle, aligned with the first BLANK cycle of digit 0, on every 3->0 wrap.
REQ-024 With en=0, counter, FSM and index SHALL hold, and an=4'b1111 and seg=7'b1111111 from the next cycle; load handshake SHALL remain functional.
REQ-025 When en returns to 1, scanning SHALL resume from the held state.
REQ-026 load_data changes without an accepted handshake SHALL have no effect.

Reset
REQ-027 With rst_n=0 at a clock edge, the block SHALL reset to: counter 0, index 0, state BLANK, display and pending registers 0, pending flag clear, an=4'b1111, seg=7'b1111111, load_ready=1, frame_start=0.
REQ-028 Reset mid-slot or with a pending value SHALL discard the pending value; the first frame_start SHALL occur on the first 3->0 wrap after release.

Structure
REQ-029 Segment code constants (digits 0..9, ERR=0110000, BLANK=1111111) and state encodings SHALL reside in shared package display_pkg.
REQ-030 Decode SHALL live in one combinational sub-module bcd_7seg_dec (4-bit in, 7-bit active-low out) instantiated once and time-shared across the four digits.

Verification (DIV=8, BLANK_CYC=2)
REQ-031 Reset then load 0x1234 -> after the first wrap, digit3..0 show 1001111, 0010010, 0000110, 1001100; each digit has 6 SHOW cycles out of 8, and frame period is 32 cycles.
REQ-032 lz_en=1, load 0x0070 -> digits 3 and 2 blank, digit1 0001111, digit0 0000001; load 0x0000 -> only digit0 lit.
REQ-033 Load 0x00A5 -> digit1 seg=0110000, digit0 0100100.
REQ-034 Hold load_valid with 0x1111 then 0x2222 back to back -> second accepted only after load_ready re-rises post-wrap; display never shows a mixed frame.
REQ-035 Accept in the same cycle as a wrap -> value appears one frame later.
REQ-036 Deassert en mid-SHOW for 5 cycles, then assert rst_n=0 mid-slot -> outputs blank and state holds while en=0; reset returns all REQ-027 values.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - segment codes and scan FSM state encoding shared by the display scanner
package display_pkg;

  // Active-low a..g, written left-to-right as a..g (a is the MSB of the literal).
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_ERR   = 7'b0110000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_7seg_dec.sv
// rtl/bcd_7seg_dec.sv - BCD nibble to active-low seven-segment code, non-BCD shows "E"
module bcd_7seg_dec
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_ERR;
    case (nibble_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/varredura_display.sv
// rtl/varredura_display.sv - four-digit multiplexed 7-segment scanner with anti-ghost blanking
// and a one-deep load buffer that is committed to the display only at frame boundaries.
module varredura_display
  import display_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        lz_en,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_start
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST       = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  state_t        state_q, state_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_q, frame_d;

  logic       slot_end, wrap, accept, suppress;
  logic [3:0] nibble;
  logic [6:0] dec_seg;
  logic [3:0] zero_from;

  bcd_7seg_dec u_dec (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  assign nibble = disp_q[{idx_q, 2'b00} +: 4];

  // zero_from[i]: digit i and every digit above it are zero; digit 0 is never blanked.
  assign zero_from[3] = (disp_q[15:12] == 4'd0);
  assign zero_from[2] = zero_from[3] && (disp_q[11:8] == 4'd0);
  assign zero_from[1] = zero_from[2] && (disp_q[7:4] == 4'd0);
  assign zero_from[0] = 1'b0;
  assign suppress     = lz_en && zero_from[idx_q];

  assign slot_end = en && (cnt_q == CNT_LAST);
  assign wrap     = slot_end && (idx_q == 2'd3);
  assign accept   = load_valid && !pend_vld_q;

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    state_d    = state_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    an_d       = AN_OFF;
    seg_d      = SEG_BLANK;
    frame_d    = wrap;

    if (en) begin
      if (slot_end) begin
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
        state_d = ST_BLANK;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_BLANK_LAST) state_d = ST_SHOW;
      end
    end

    // Accept only happens with the buffer empty, so it never races a commit.
    if (wrap && pend_vld_q) begin
      disp_d     = pend_q;
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      pend_d     = load_data;
      pend_vld_d = 1'b1;
    end

    if (en && state_q == ST_SHOW) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = suppress ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      state_q    <= ST_BLANK;
      disp_q     <= 16'h0000;
      pend_q     <= 16'h0000;
      pend_vld_q <= 1'b0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_BLANK;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      frame_q    <= frame_d;
    end
  end

  assign load_ready  = !pend_vld_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_varredura_display.sv
// tb/tb_varredura_display.sv - directed self-checking bench for varredura_display (DIV=8, BLANK_CYC=2)
module tb_varredura_display;

  localparam logic [6:0] C0 = 7'b0000001;
  localparam logic [6:0] C1 = 7'b1001111;
  localparam logic [6:0] C2 = 7'b0010010;
  localparam logic [6:0] C3 = 7'b0000110;
  localparam logic [6:0] C4 = 7'b1001100;
  localparam logic [6:0] C5 = 7'b0100100;
  localparam logic [6:0] C6 = 7'b0100000;
  localparam logic [6:0] C7 = 7'b0001111;
  localparam logic [6:0] C8 = 7'b0000000;
  localparam logic [6:0] CE = 7'b0110000;
  localparam logic [6:0] CB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n, en, lz_en, load_valid;
  logic [15:0] load_data;
  logic        load_ready, frame_start;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  varredura_display #(.DIV(8), .BLANK_CYC(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .lz_en       (lz_en),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 40);
    chk({tag, "_fs"}, 16'(frame_start), 16'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input string tag);
    int n;
    n = 0;
    while (!load_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 16'(load_ready), 16'd1);
    load_valid = 1'b1;
    load_data  = d;
    @(negedge clk);
    load_valid = 1'b0;
    chk({tag, "_acc"}, 16'(load_ready), 16'd0);
  endtask

  // Called at the negedge where frame_start is high; checks offsets 1..32 of that frame.
  task automatic check_body(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input bit drop_valid, input string tag);
    logic [6:0] s[4];
    logic [3:0] ea;
    logic [6:0] es;
    int k, r;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int o = 1; o <= 32; o++) begin
      @(negedge clk);
      k = (o - 1) / 8;
      r = (o - 1) % 8;
      if (r < 2) begin
        ea = 4'hF;
        es = CB;
      end else begin
        ea = ~(4'b0001 << k);
        es = s[k];
      end
      chk($sformatf("%s_an_o%0d", tag, o), 16'(an), 16'(ea));
      chk($sformatf("%s_seg_o%0d", tag, o), 16'(seg), 16'(es));
      chk($sformatf("%s_fs_o%0d", tag, o), 16'(frame_start), (o == 32) ? 16'd1 : 16'd0);
      if (drop_valid && o == 1) begin
        chk({tag, "_second_taken"}, 16'(load_ready), 16'd0);
        load_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; lz_en = 1'b0; load_valid = 1'b0; load_data = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'(CB));
    chk("rst_ready", 16'(load_ready), 16'd1);
    chk("rst_fs", 16'(frame_start), 16'd0);
    rst_n = 1'b1; en = 1'b1;

    do_load(16'h1234, "l1234");
    wait_fs("f1234");
    check_body(C4, C3, C2, C1, 1'b0, "f1234");
    chk("ready_after_wrap", 16'(load_ready), 16'd1);

    lz_en = 1'b1;
    do_load(16'h0070, "l0070");
    wait_fs("f0070");
    check_body(C0, C7, CB, CB, 1'b0, "f0070");

    do_load(16'h0000, "l0000");
    wait_fs("f0000");
    check_body(C0, CB, CB, CB, 1'b0, "f0000");

    lz_en = 1'b0;
    do_load(16'h00A5, "l00a5");
    wait_fs("f00a5");
    check_body(C5, CE, C0, C0, 1'b0, "f00a5");

    load_valid = 1'b1;
    load_data  = 16'h1111;
    @(negedge clk);
    load_data  = 16'h2222;
    chk("b2b_first_taken", 16'(load_ready), 16'd0);
    wait_fs("b2b");
    chk("b2b_ready_rise", 16'(load_ready), 16'd1);
    check_body(C1, C1, C1, C1, 1'b1, "f1111");
    check_body(C2, C2, C2, C2, 1'b0, "f2222");

    repeat (31) @(negedge clk);
    chk("wacc_ready", 16'(load_ready), 16'd1);
    load_valid = 1'b1;
    load_data  = 16'h5678;
    @(negedge clk);
    load_valid = 1'b0;
    chk("wacc_fs", 16'(frame_start), 16'd1);
    chk("wacc_taken", 16'(load_ready), 16'd0);
    check_body(C2, C2, C2, C2, 1'b0, "wacc_old");
    check_body(C8, C7, C6, C5, 1'b0, "f5678");

    repeat (5) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_an_%0d", i), 16'(an), 16'hF);
      chk($sformatf("hold_seg_%0d", i), 16'(seg), 16'(CB));
      chk($sformatf("hold_fs_%0d", i), 16'(frame_start), 16'd0);
    end
    en = 1'b1;
    @(negedge clk);
    chk("resume_an", 16'(an), 16'hE);
    chk("resume_seg", 16'(seg), 16'(C8));

    do_load(16'h9999, "l9999");
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_an", 16'(an), 16'hF);
    chk("rst2_seg", 16'(seg), 16'(CB));
    chk("rst2_ready", 16'(load_ready), 16'd1);
    chk("rst2_fs", 16'(frame_start), 16'd0);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 40);
    chk("rst2_first_fs_cycle", 16'(n), 16'd32);
    check_body(C0, C0, C0, C0, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
